// File: rtl/io_in_conditioner_pkg.sv
// Shared widths and defaults for the board input conditioning path.
package io_pkg;

   localparam int unsigned IO_SW_W            = 32;
   localparam int unsigned IO_BTN_W           = 4;
   localparam int unsigned DEF_TICK_DIV       = 50000;
   localparam int unsigned DEF_BTN_STABLE     = 4;
   localparam int unsigned DEF_SW_STABLE      = 2;
   localparam int unsigned DEF_BTN_ACTIVE_LOW = 1;

   // Counter width able to hold 0..n-1, never narrower than one bit.
   function automatic int unsigned cnt_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/io_in_conditioner_debounce_bit.sv
// One conditioned input bit: 2-flop synchroniser, tick-qualified debounce
// counter, registered level and one-cycle rise/fall pulses.
module debounce_bit
   import io_pkg::*;
#(
   parameter int unsigned STABLE = DEF_SW_STABLE
) (
   input  logic clk,
   input  logic rst_n,
   input  logic tick,
   input  logic raw,
   output logic level,
   output logic rise,
   output logic fall
);

   localparam int unsigned CW = cnt_w(STABLE);

   logic          sync_1;
   logic          sync_2;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_1 <= 1'b0;
         sync_2 <= 1'b0;
      end else begin
         sync_1 <= raw;
         sync_2 <= sync_1;
      end
   end

   // Any agreeing tick restarts qualification from zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt   <= '0;
         level <= 1'b0;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         rise <= 1'b0;
         fall <= 1'b0;
         if (tick) begin
            if (sync_2 == level) begin
               cnt <= '0;
            end else if (cnt == CW'(STABLE - 1)) begin
               level <= sync_2;
               rise  <= sync_2;
               fall  <= ~sync_2;
               cnt   <= '0;
            end else begin
               cnt <= cnt + CW'(1);
            end
         end
      end
   end

endmodule

// File: rtl/io_in_conditioner.sv
// Board switch/button conditioner feeding the core's i_io_sw / i_io_btn,
// with press/release pulses for event use.
module io_in_conditioner
   import io_pkg::*;
#(
   parameter int unsigned TICK_DIV       = DEF_TICK_DIV,
   parameter int unsigned BTN_STABLE     = DEF_BTN_STABLE,
   parameter int unsigned SW_STABLE      = DEF_SW_STABLE,
   parameter int unsigned BTN_ACTIVE_LOW = DEF_BTN_ACTIVE_LOW
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic [IO_SW_W-1:0]  i_sw_raw,
   input  logic [IO_BTN_W-1:0] i_btn_raw,
   output logic [IO_SW_W-1:0]  o_io_sw,
   output logic [IO_BTN_W-1:0] o_io_btn,
   output logic [IO_BTN_W-1:0] o_btn_press,
   output logic [IO_BTN_W-1:0] o_btn_release
);

   localparam int unsigned         TW      = cnt_w(TICK_DIV);
   localparam logic [IO_BTN_W-1:0] BTN_POL = (BTN_ACTIVE_LOW != 0) ? '1 : '0;

   logic [TW-1:0]       tick_cnt;
   logic                tick;
   logic [IO_BTN_W-1:0] btn_norm;
   logic [IO_SW_W-1:0]  sw_rise_unused;
   logic [IO_SW_W-1:0]  sw_fall_unused;

   always_comb begin
      tick     = (tick_cnt == TW'(TICK_DIV - 1));
      btn_norm = i_btn_raw ^ BTN_POL;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         tick_cnt <= '0;
      end else if (tick) begin
         tick_cnt <= '0;
      end else begin
         tick_cnt <= tick_cnt + TW'(1);
      end
   end

   for (genvar g = 0; g < IO_SW_W; g++) begin : g_sw
      debounce_bit #(.STABLE(SW_STABLE)) u_db (
         .clk   (i_clk),
         .rst_n (i_rst_n),
         .tick  (tick),
         .raw   (i_sw_raw[g]),
         .level (o_io_sw[g]),
         .rise  (sw_rise_unused[g]),
         .fall  (sw_fall_unused[g])
      );
   end

   for (genvar g = 0; g < IO_BTN_W; g++) begin : g_btn
      debounce_bit #(.STABLE(BTN_STABLE)) u_db (
         .clk   (i_clk),
         .rst_n (i_rst_n),
         .tick  (tick),
         .raw   (btn_norm[g]),
         .level (o_io_btn[g]),
         .rise  (o_btn_press[g]),
         .fall  (o_btn_release[g])
      );
   end

endmodule

// File: tb/tb_io_in_conditioner.sv
// Directed bench for io_in_conditioner with a timestamp-based reference model
// checked every cycle, plus literal latency/value expectations.
module tb_io_in_conditioner;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] sw_raw;
   logic [3:0]  btn_raw;

   logic [31:0] sw_a, sw_b;
   logic [3:0]  btn_a, btn_b, prs_a, prs_b, rel_a, rel_b;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   io_in_conditioner #(.TICK_DIV(4), .BTN_STABLE(3), .SW_STABLE(2), .BTN_ACTIVE_LOW(1)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_sw_raw(sw_raw), .i_btn_raw(btn_raw),
      .o_io_sw(sw_a), .o_io_btn(btn_a), .o_btn_press(prs_a), .o_btn_release(rel_a)
   );

   io_in_conditioner #(.TICK_DIV(1), .BTN_STABLE(3), .SW_STABLE(2), .BTN_ACTIVE_LOW(1)) dut1 (
      .i_clk(clk), .i_rst_n(rst_n), .i_sw_raw(sw_raw), .i_btn_raw(btn_raw),
      .o_io_sw(sw_b), .o_io_btn(btn_b), .o_btn_press(prs_b), .o_btn_release(rel_b)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_range(input string name, input int v, input int lo, input int hi);
      n_cmp++;
      if (v < lo || v > hi) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d..%0d at %0t", name, v, lo, hi, $time);
      end
   endtask

   // Reference model: a bit flips on the tick where the last S tick samples,
   // all taken since its last agreement or flip, disagree with its level.
   int          tdiv[2] = '{4, 1};
   logic [35:0] m_d1[2], m_d2[2], m_out[2];
   logic [3:0]  m_prs[2], m_rel[2];
   int          m_edges[2], m_ticks[2];
   int          m_last[2][36];

   task automatic m_reset();
      for (int m = 0; m < 2; m++) begin
         m_d1[m] = '0; m_d2[m] = '0; m_out[m] = '0;
         m_prs[m] = '0; m_rel[m] = '0;
         m_edges[m] = 0; m_ticks[m] = 0;
         for (int b = 0; b < 36; b++) m_last[m][b] = -1;
      end
   endtask

   task automatic m_step();
      logic [35:0] norm, prev;
      int          stable;
      norm = {~btn_raw, sw_raw};
      for (int m = 0; m < 2; m++) begin
         prev = m_out[m];
         if (m_edges[m] % tdiv[m] == tdiv[m] - 1) begin
            for (int b = 0; b < 36; b++) begin
               stable = (b < 32) ? 2 : 3;
               if (m_d2[m][b] == m_out[m][b]) begin
                  m_last[m][b] = m_ticks[m];
               end else if (m_ticks[m] - m_last[m][b] >= stable) begin
                  m_out[m][b]  = ~m_out[m][b];
                  m_last[m][b] = m_ticks[m];
               end
            end
            m_ticks[m]++;
         end
         m_prs[m] = m_out[m][35:32] & ~prev[35:32];
         m_rel[m] = ~m_out[m][35:32] & prev[35:32];
         m_d2[m] = m_d1[m];
         m_d1[m] = norm;
         m_edges[m]++;
      end
   endtask

   initial begin
      m_reset();
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) m_reset();
         else        m_step();
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         check("model.sw4",  sw_a,  m_out[0][31:0]);
         check("model.btn4", btn_a, m_out[0][35:32]);
         check("model.prs4", prs_a, m_prs[0]);
         check("model.rel4", rel_a, m_rel[0]);
         check("model.sw1",  sw_b,  m_out[1][31:0]);
         check("model.btn1", btn_b, m_out[1][35:32]);
         check("model.prs1", prs_b, m_prs[1]);
         check("model.rel1", rel_b, m_rel[1]);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   int   n, na, nb;
   logic seen;
   logic [3:0] pa, pb;

   initial begin
      rst_n   = 1'b0;
      btn_raw = 4'hF;
      sw_raw  = 32'hFFFF_FFFF;
      repeat (3) @(negedge clk);
      check("reset.sw",  sw_a,  32'h0);
      check("reset.btn", btn_a, 4'h0);
      check("reset.prs", prs_a, 4'h0);
      check("reset.rel", rel_a, 4'h0);
      sw_raw = 32'h0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);

      // Clean press and release of button 0
      btn_raw[0] = 1'b0;
      n = 0;
      while (n < 40 && !btn_a[0]) begin @(posedge clk); #1; n++; end
      check_range("press.latency", n, 11, 14);
      check("press.pulse", prs_a, 4'b0001);
      @(posedge clk); #1;
      check("press.pulse_width", prs_a, 4'b0000);
      check("press.level_held", btn_a, 4'b0001);
      @(negedge clk);
      btn_raw[0] = 1'b1;
      n = 0;
      while (n < 40 && btn_a[0]) begin @(posedge clk); #1; n++; end
      check_range("release.latency", n, 11, 14);
      check("release.pulse", rel_a, 4'b0001);
      @(posedge clk); #1;
      check("release.pulse_width", rel_a, 4'b0000);

      // Short bounce on button 1 must be rejected
      @(negedge clk);
      btn_raw[1] = 1'b0;
      repeat (5) @(negedge clk);
      btn_raw[1] = 1'b1;
      seen = 1'b0;
      repeat (30) begin
         @(posedge clk); #1;
         seen = seen | btn_a[1] | prs_a[1] | rel_a[1];
      end
      check("bounce.reject", {31'b0, seen}, 32'h0);

      // Switch word change, all bits on one edge
      @(negedge clk);
      sw_raw = 32'hA5A5_0F0F;
      n = 0;
      while (n < 40 && sw_a == 32'h0) begin @(posedge clk); #1; n++; end
      check_range("sw.latency", n, 7, 10);
      check("sw.value", sw_a, 32'hA5A5_0F0F);

      // Reset in the middle of qualifying button 2
      @(negedge clk);
      btn_raw[2] = 1'b0;
      repeat (8) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("rst_mid.sw_async", sw_a, 32'h0);
      check("rst_mid.btn_async", btn_a, 4'h0);
      repeat (3) @(negedge clk);
      check("rst_mid.btn_held", btn_a, 4'h0);
      rst_n = 1'b1;
      n = 0;
      while (n < 40 && !btn_a[2]) begin @(posedge clk); #1; n++; end
      check_range("rst_mid.latency", n, 11, 14);
      check("rst_mid.pulse", prs_a, 4'b0100);

      @(negedge clk);
      btn_raw = 4'hF;
      repeat (25) @(negedge clk);

      // All four buttons pressed together, on both tick rates
      btn_raw = 4'h0;
      n = 0; na = 0; nb = 0; pa = '0; pb = '0;
      while (n < 40 && (na == 0 || nb == 0)) begin
         @(posedge clk); #1; n++;
         if (na == 0 && prs_a != 4'h0) begin na = n; pa = prs_a; end
         if (nb == 0 && prs_b != 4'h0) begin nb = n; pb = prs_b; end
      end
      check("simul.press_div4", pa, 4'hF);
      check_range("simul.latency_div4", na, 11, 14);
      check("simul.press_div1", pb, 4'hF);
      check_range("simul.latency_div1", nb, 3, 5);

      @(negedge clk);
      btn_raw = 4'hF;
      repeat (25) @(negedge clk);
      check("final.btn", btn_a, 4'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
